// File: rtl/hazard_ctrl_param_pkg.sv
// Shared types for the parametrised hazard/stall controller.
// Register index constants name the pipeline registers, IF/ID first.
package hazard_ctrl_param_pkg;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    KILL
  } hazard_state_t;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall-cause counters, built only with HAZARD_PERF_CNT_EN.
// One event per cycle at most; each counter sticks at all-ones.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_dmiss,
  input  logic             ev_imiss,
  input  logic             ev_lu,
  input  logic             ev_redir,
  output logic [CNT_W-1:0] dmiss_cycles,
  output logic [CNT_W-1:0] imiss_cycles,
  output logic [CNT_W-1:0] lu_bubbles,
  output logic [CNT_W-1:0] redirects
);

  logic [3:0]       ev;
  logic [CNT_W-1:0] cnt [4];

  assign ev = {ev_redir, ev_lu, ev_imiss, ev_dmiss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ev[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign dmiss_cycles = cnt[0];
  assign imiss_cycles = cnt[1];
  assign lu_bubbles   = cnt[2];
  assign redirects    = cnt[3];

endmodule
`endif

// File: rtl/hazard_ctrl_param.sv
// N-stage hazard/stall controller: D-miss freeze, redirect, load-use, I-miss.
// Define HAZARD_PERF_CNT_EN to add the saturating stall-cause counters.
module hazard_ctrl_param
  import hazard_ctrl_param_pkg::*;
#(
  parameter int NUM_STAGES      = 5,
  parameter int LOAD_USE_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W           = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_resp,
  input  logic                  data_req,
  input  logic                  data_resp,
  input  logic                  ex_is_load,
  input  rv32i_reg              ex_rd,
  input  rv32i_reg              id_rs1,
  input  rv32i_reg              id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  redirect,
  output logic                  load_pc,
  output logic                  inst_read,
  output logic                  drop_inst_resp,
  output logic [NUM_STAGES-2:0] reg_load,
  output logic [NUM_STAGES-2:0] reg_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      dmiss_cycles,
  output logic [CNT_W-1:0]      imiss_cycles,
  output logic [CNT_W-1:0]      lu_bubbles,
  output logic [CNT_W-1:0]      redirects
`endif
);

  localparam int R = NUM_STAGES - 1;
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYCLES - 1);

  hazard_state_t state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          fetch_out, fo_n;
  logic          freeze, lu_haz, stop;
  logic [R-1:0]  flush, hold;

  assign freeze = data_req && !data_resp;
  assign lu_haz = ex_is_load && (ex_rd != '0) &&
                  ((id_use_rs1 && id_rs1 == ex_rd) ||
                   (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    flush   = '0;
    hold    = '0;
    stop    = 1'b0;
    load_pc = 1'b1;
    state_n = state;
    cnt_n   = cnt;
    fo_n    = inst_resp ? 1'b0 : (inst_read | fetch_out);
    priority case (1'b1)
      !rst_n: begin
        flush   = '1;
        stop    = 1'b1;
        load_pc = 1'b0;
      end
      freeze: begin
        stop    = 1'b1;
        load_pc = 1'b0;
        fo_n    = fetch_out;
      end
      redirect: begin
        flush[IF_ID] = 1'b1;
        flush[ID_EX] = 1'b1;
        cnt_n        = '0;
        state_n      = (fetch_out && !inst_resp) ? KILL : RUN;
      end
      state == KILL: begin
        flush[IF_ID] = 1'b1;
        load_pc      = 1'b0;
        state_n      = inst_resp ? RUN : KILL;
      end
      state == LU_STALL: begin
        hold[IF_ID]  = 1'b1;
        flush[ID_EX] = 1'b1;
        load_pc      = 1'b0;
        cnt_n        = cnt - 3'd1;
        state_n      = (cnt == 3'd1) ? RUN : LU_STALL;
      end
      lu_haz: begin
        hold[IF_ID]  = 1'b1;
        flush[ID_EX] = 1'b1;
        load_pc      = 1'b0;
        if (LOAD_USE_CYCLES > 1) begin
          state_n = LU_STALL;
          cnt_n   = LU_INIT;
        end
      end
      !inst_resp: begin
        flush[IF_ID] = 1'b1;
        load_pc      = 1'b0;
      end
      default: ;
    endcase
  end

  assign inst_read      = rst_n;
  assign drop_inst_resp = rst_n && (state == KILL);
  assign reg_flush      = flush;
  assign reg_load       = stop ? '0 : ~(flush | hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      fetch_out <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fetch_out <= fo_n;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic ev_dmiss, ev_imiss, ev_lu, ev_redir;

  assign ev_dmiss = freeze;
  assign ev_redir = !freeze && redirect;
  assign ev_lu    = !freeze && !redirect &&
                    (state == LU_STALL || (state == RUN && lu_haz));
  assign ev_imiss = !freeze && !redirect && state == RUN &&
                    !lu_haz && !inst_resp;

  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_dmiss     (ev_dmiss),
    .ev_imiss     (ev_imiss),
    .ev_lu        (ev_lu),
    .ev_redir     (ev_redir),
    .dmiss_cycles (dmiss_cycles),
    .imiss_cycles (imiss_cycles),
    .lu_bubbles   (lu_bubbles),
    .redirects    (redirects)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Self-checking bench for hazard_ctrl_param (default build).
// Reference model tracks kill/bubble/outstanding as plain variables.
module tb_hazard_ctrl_param;

  localparam int NS  = 5;
  localparam int R   = NS - 1;
  localparam int LUC = 4;
  localparam int W   = 2 * R + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inst_resp, data_req, data_resp, ex_is_load;
  logic id_use_rs1, id_use_rs2, redirect;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic load_pc, inst_read, drop_inst_resp;
  logic [R-1:0] reg_load, reg_flush;

  int n_checks = 0;
  int n_fail = 0;

  bit m_kill = 1'b0;
  bit m_out = 1'b1;
  int m_bub = 0;
  bit nx_kill, nx_out;
  int nx_bub;
  logic [W-1:0] exp_v;

  always #5 clk = ~clk;

  hazard_ctrl_param #(
    .NUM_STAGES      (NS),
    .LOAD_USE_CYCLES (LUC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_resp      (inst_resp),
    .data_req       (data_req),
    .data_resp      (data_resp),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .redirect       (redirect),
    .load_pc        (load_pc),
    .inst_read      (inst_read),
    .drop_inst_resp (drop_inst_resp),
    .reg_load       (reg_load),
    .reg_flush      (reg_flush)
  );

  function automatic logic [W-1:0] obs();
    return {load_pc, inst_read, drop_inst_resp, reg_load, reg_flush};
  endfunction

  function automatic void model_eval();
    logic [R-1:0] fl, hd;
    logic pc, hz;
    fl = '0;
    hd = '0;
    pc = 1'b1;
    nx_kill = m_kill;
    nx_out  = m_out;
    nx_bub  = m_bub;
    hz = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n) begin
      exp_v = {3'b000, {R{1'b0}}, {R{1'b1}}};
      nx_kill = 1'b0;
      nx_out = 1'b1;
      nx_bub = 0;
      return;
    end
    if (data_req && !data_resp) begin
      exp_v = {2'b01, m_kill, {R{1'b0}}, {R{1'b0}}};
      return;
    end
    nx_out = !inst_resp;
    if (redirect) begin
      fl[0] = 1'b1;
      fl[1] = 1'b1;
      nx_bub = 0;
      nx_kill = m_out && !inst_resp;
    end else if (m_kill) begin
      fl[0] = 1'b1;
      pc = 1'b0;
      nx_kill = !inst_resp;
    end else if (m_bub > 0 || hz) begin
      hd[0] = 1'b1;
      fl[1] = 1'b1;
      pc = 1'b0;
      nx_bub = (m_bub > 0) ? m_bub - 1 : LUC - 1;
    end else if (!inst_resp) begin
      fl[0] = 1'b1;
      pc = 1'b0;
    end
    exp_v = {pc, 1'b1, m_kill, ~(fl | hd), fl};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_eval();
    m_kill = nx_kill;
    m_out  = nx_out;
    m_bub  = nx_bub;
    #1;
  endtask

  task automatic idle();
    inst_resp = 1'b1;
    data_req = 1'b0;
    data_resp = 1'b0;
    ex_is_load = 1'b0;
    ex_rd = '0;
    id_rs1 = '0;
    id_rs2 = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL reset cyc%0d got %b want %b", i, obs(), exp_v);
      end
      if (i == 1) rst_n = 1'b1;
      tick();
    end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    idle();
    ex_is_load = 1'b1;
    ex_rd = 5'd5;
    id_rs1 = 5'd5;
    id_use_rs1 = 1'b1;
    for (int i = 0; i < LUC + 2; i++) begin
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL load_use cyc%0d got %b want %b", i, obs(), exp_v);
      end
      if (!load_pc && !reg_load[0] && reg_flush[1]) stalls++;
      tick();
      ex_is_load = 1'b0;
    end
    n_checks++;
    if (stalls != LUC) begin
      n_fail++;
      $display("FAIL load_use_len got %0d want %0d", stalls, LUC);
    end
  endtask

  task automatic test_rd_zero();
    idle();
    ex_is_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex_rd = 5'd0;
      id_rs1 = 5'd0;
      id_rs2 = 5'd0;
      id_use_rs1 = (i == 0);
      id_use_rs2 = (i == 1);
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v || reg_load !== {R{1'b1}}) begin
        n_fail++;
        $display("FAIL rd_zero cyc%0d got %b want %b", i, obs(), exp_v);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_redirect_kill();
    int drops;
    drops = 0;
    idle();
    inst_resp = 1'b0;
    #3;
    model_eval();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL imiss got %b want %b", obs(), exp_v);
    end
    tick();
    redirect = 1'b1;
    #3;
    model_eval();
    n_checks++;
    if (obs() !== exp_v || reg_flush[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL redirect got %b want %b", obs(), exp_v);
    end
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inst_resp = (i >= 3);
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL kill cyc%0d got %b want %b", i, obs(), exp_v);
      end
      if (drop_inst_resp) drops++;
      tick();
    end
    n_checks++;
    if (drops != 4) begin
      n_fail++;
      $display("FAIL kill_drops got %0d want 4", drops);
    end
    idle();
  endtask

  task automatic test_dmiss();
    int frozen;
    frozen = 0;
    idle();
    redirect = 1'b1;
    data_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_resp = (i >= 4);
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL dmiss cyc%0d got %b want %b", i, obs(), exp_v);
      end
      if (reg_load === '0) frozen++;
      if (i == 4 && (load_pc !== 1'b1 || reg_flush[1:0] !== 2'b11)) begin
        n_fail++;
        $display("FAIL dmiss_release got pc=%b fl=%b want pc=1 fl=11",
                 load_pc, reg_flush[1:0]);
      end
      tick();
      if (i == 4) redirect = 1'b0;
    end
    n_checks += 2;
    if (frozen != 4) begin
      n_fail++;
      $display("FAIL dmiss_len got %0d want 4", frozen);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    ex_is_load = 1'b1;
    ex_rd = 5'd7;
    id_rs2 = 5'd7;
    id_use_rs2 = 1'b1;
    #3;
    model_eval();
    tick();
    ex_is_load = 1'b0;
    #1;
    model_eval();
    n_checks++;
    if (obs() !== exp_v || m_bub != 3) begin
      n_fail++;
      $display("FAIL mid_stall got %b want %b", obs(), exp_v);
    end
    #1;
    rst_n = 1'b0;
    m_kill = 1'b0;
    m_out = 1'b1;
    m_bub = 0;
    #1;
    model_eval();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL async_rst got %b want %b", obs(), exp_v);
    end
    tick();
    rst_n = 1'b1;
    #3;
    model_eval();
    n_checks++;
    if (obs() !== exp_v || inst_read !== 1'b1 || load_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst got %b want %b", obs(), exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      inst_resp  = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 3) == 0);
      data_resp  = $urandom_range(0, 1) == 1;
      redirect   = ($urandom_range(0, 7) == 0);
      ex_is_load = $urandom_range(0, 1) == 1;
      ex_rd      = 5'($urandom_range(0, 3));
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1) == 1;
      id_use_rs2 = $urandom_range(0, 1) == 1;
      #3;
      model_eval();
      n_checks++;
      if (obs() !== exp_v || (reg_load & reg_flush) !== '0) begin
        n_fail++;
        $display("FAIL random cyc%0d got %b want %b", i, obs(), exp_v);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect_kill();
    test_dmiss();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
